// File: rtl/dircc_packet_queue.sv
// dircc_packet_queue: per-channel packet FIFOs between the DiRCC network interface and the
// device handler. Ingress is steered by dest_addr.port modulo NUM_CHANNELS; a round-robin
// arbiter drains the FIFOs into a registered valid/ready egress stage.
// Optional feature macro: DIRCC_LAMPORT_STAMP_EN (Lamport clock update and egress restamping).
module dircc_packet_queue #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_BYTES   = 12,
  localparam int unsigned PKT_W       = 144 + 8 * DATA_BYTES,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1),
  localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PKT_W-1:0]              in_packet,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PKT_W-1:0]              out_packet,
  output logic [CH_W-1:0]               out_channel,
  output logic [NUM_CHANNELS*CNT_W-1:0] chan_count,
  output logic [31:0]                   lamport_now
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LAM_LSB = 8 * DATA_BYTES;

  logic [PKT_W-1:0] mem      [NUM_CHANNELS][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [NUM_CHANNELS];
  logic [PTR_W-1:0] rd_ptr_q [NUM_CHANNELS];
  logic [CNT_W-1:0] count_q  [NUM_CHANNELS];
  logic [PKT_W-1:0] head     [NUM_CHANNELS];

  logic [7:0]       in_port;
  logic [CH_W-1:0]  in_ch;
  logic [CH_W-1:0]  rr_q;
  logic [CH_W-1:0]  grant_ch;
  logic [CH_W-1:0]  cand;
  logic             grant_valid;
  logic             push;
  logic             load;
  logic             pop;
  logic [PKT_W-1:0] load_packet;

  logic             out_valid_q;
  logic [PKT_W-1:0] out_packet_q;
  logic [CH_W-1:0]  out_channel_q;

  // Steering: dest port field selects the channel.
  assign in_port  = in_packet[PKT_W-41 -: 8];
  assign in_ch    = CH_W'(in_port % 8'(NUM_CHANNELS));
  // Held low while in reset; no bypass when the target channel is full.
  assign in_ready = reset_n && (count_q[in_ch] != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;

  // Egress register accepts a new packet when empty or being consumed this cycle.
  assign load = !out_valid_q || out_ready;
  assign pop  = load && grant_valid;

  // Round-robin grant: first non-empty channel strictly after the last granted one.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = rr_q;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      cand = CH_W'((32'(rr_q) + i) % NUM_CHANNELS);
      if (!grant_valid && (count_q[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  // One read port per channel, muxed by the grant.
  always_comb begin
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      head[c] = mem[c][rd_ptr_q[c]];
    end
  end

  // Storage write port; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[in_ch][wr_ptr_q[in_ch]] <= in_packet;
    end
  end

  // Per-channel pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
        if (push && (in_ch == CH_W'(c))) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        end
        if (pop && (grant_ch == CH_W'(c))) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        end
        if ((push && (in_ch == CH_W'(c))) && !(pop && (grant_ch == CH_W'(c)))) begin
          count_q[c] <= count_q[c] + CNT_W'(1);
        end else if (!(push && (in_ch == CH_W'(c))) && (pop && (grant_ch == CH_W'(c)))) begin
          count_q[c] <= count_q[c] - CNT_W'(1);
        end
      end
    end
  end

`ifdef DIRCC_LAMPORT_STAMP_EN
  logic [31:0] lam_q;
  logic [31:0] lam_in;
  logic [31:0] lam_ing;
  logic [31:0] lam_load;

  assign lam_in = in_packet[LAM_LSB +: 32];

  // Ingress merge first, then the egress load stamps the post-ingress value plus one.
  always_comb begin
    lam_ing  = push ? (((lam_in > lam_q) ? lam_in : lam_q) + 32'd1) : lam_q;
    lam_load = lam_ing + 32'd1;
  end

  // Local Lamport clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lam_q <= '0;
    end else if (pop) begin
      lam_q <= lam_load;
    end else begin
      lam_q <= lam_ing;
    end
  end

  // Granted head with its lamport field restamped.
  always_comb begin
    load_packet                  = head[grant_ch];
    load_packet[LAM_LSB +: 32]   = lam_load;
  end

  assign lamport_now = lam_q;
`else
  // Granted head, passed bit-exact.
  always_comb begin
    load_packet = head[grant_ch];
  end

  assign lamport_now = '0;
`endif

  // Egress register and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_packet_q  <= '0;
      out_channel_q <= '0;
      rr_q          <= CH_W'(NUM_CHANNELS - 1);
    end else if (load) begin
      out_valid_q <= grant_valid;
      if (grant_valid) begin
        out_packet_q  <= load_packet;
        out_channel_q <= grant_ch;
        rr_q          <= grant_ch;
      end
    end
  end

  // Occupancy export, channel c at [c*CNT_W +: CNT_W].
  always_comb begin
    chan_count = '0;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      chan_count[c*CNT_W +: CNT_W] = count_q[c];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_packet  = out_packet_q;
  assign out_channel = out_channel_q;

endmodule

// File: tb/tb_dircc_packet_queue.sv
// Self-checking bench for dircc_packet_queue: queue-based reference model compared every cycle,
// plus directed literal checks for reset, latency, full channel, arbitration order and Lamport.
module tb_dircc_packet_queue;

  localparam int NCH        = 4;
  localparam int DEPTH      = 8;
  localparam int DATA_BYTES = 12;
  localparam int PKT_W      = 240;
  localparam int CNT_W      = 4;
  localparam int CH_W       = 2;
  localparam int LAM_LSB    = 96;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [PKT_W-1:0]      in_packet;
  logic                  out_valid;
  logic                  out_ready;
  logic [PKT_W-1:0]      out_packet;
  logic [CH_W-1:0]       out_channel;
  logic [NCH*CNT_W-1:0]  chan_count;
  logic [31:0]           lamport_now;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state.
  logic [PKT_W-1:0] mq [NCH][$];
  bit               exp_valid;
  logic [PKT_W-1:0] exp_pkt;
  int               exp_ch;
  int               rr;
  logic [31:0]      exp_lam;
  int               m_pushed = 0;
  int               m_delivered = 0;

  // Model scratch.
  int               m_cin;
  bit               m_fire;
  bit               m_load;
  bit               m_found;
  int               m_g;
  int               m_c;
  logic [31:0]      m_li;
  logic [31:0]      m_inlam;
  logic [PKT_W-1:0] m_p;

  dircc_packet_queue #(
    .NUM_CHANNELS(NCH),
    .DEPTH       (DEPTH),
    .DATA_BYTES  (DATA_BYTES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .out_channel(out_channel),
    .chan_count (chan_count),
    .lamport_now(lamport_now)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int ch_of(input logic [PKT_W-1:0] p);
    return int'(p[PKT_W-41 -: 8]) % NCH;
  endfunction

  function automatic logic [PKT_W-1:0] mk(input int port, input logic [31:0] lam);
    logic [255:0]     t;
    logic [PKT_W-1:0] p;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    p = t[PKT_W-1:0];
    p[PKT_W-41 -: 8]  = 8'(port);
    p[LAM_LSB +: 32]  = lam;
    return p;
  endfunction

  function automatic bit any_queued();
    for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: channel queues, a single output slot and a round-robin index.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      exp_valid = 1'b0;
      exp_pkt   = '0;
      exp_ch    = 0;
      rr        = NCH - 1;
      exp_lam   = '0;
    end else begin
      m_cin   = ch_of(in_packet);
      m_fire  = in_valid && (mq[m_cin].size() != DEPTH);
      m_load  = !exp_valid || out_ready;
      m_inlam = in_packet[LAM_LSB +: 32];
      m_li    = exp_lam;
`ifdef DIRCC_LAMPORT_STAMP_EN
      if (m_fire) m_li = ((m_inlam > exp_lam) ? m_inlam : exp_lam) + 32'd1;
`endif
      if (exp_valid && out_ready) m_delivered++;
      if (m_load) begin
        m_found = 1'b0;
        m_g     = 0;
        for (int i = 1; i <= NCH; i++) begin
          m_c = (rr + i) % NCH;
          if (!m_found && mq[m_c].size() != 0) begin
            m_found = 1'b1;
            m_g     = m_c;
          end
        end
        exp_valid = m_found;
        if (m_found) begin
          m_p = mq[m_g].pop_front();
`ifdef DIRCC_LAMPORT_STAMP_EN
          m_li = m_li + 32'd1;
          m_p[LAM_LSB +: 32] = m_li;
`endif
          exp_pkt = m_p;
          exp_ch  = m_g;
          rr      = m_g;
        end
      end
      exp_lam = m_li;
      if (m_fire) begin
        mq[m_cin].push_back(in_packet);
        m_pushed++;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en && reset_n) begin
      chk("out_valid", 256'(out_valid), 256'(exp_valid));
      if (exp_valid) begin
        chk("out_packet", 256'(out_packet), 256'(exp_pkt));
        chk("out_channel", 256'(out_channel), 256'(exp_ch));
      end
      for (int c = 0; c < NCH; c++) begin
        chk("chan_count", 256'(chan_count[c*CNT_W +: CNT_W]), 256'(mq[c].size()));
      end
      chk("in_ready", 256'(in_ready), 256'(mq[ch_of(in_packet)].size() != DEPTH));
      chk("lamport_now", 256'(lamport_now), 256'(exp_lam));
    end
  end

  logic [PKT_W-1:0] p2;
  int               order [6] = '{0, 1, 3, 0, 1, 3};
  int               ports [6] = '{0, 1, 3, 0, 1, 3};
  int               base;
  int               cyc;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_packet = mk(1, 32'd0);
    repeat (3) tick();

    // Reset state.
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_chan_count", 256'(chan_count), 256'(0));
    chk("rst_lamport", 256'(lamport_now), 256'(0));
    #1 reset_n = 1'b1;
    check_en = 1'b1;
    for (int p = 0; p < NCH; p++) begin
      in_packet = mk(p, 32'd0);
      #1 chk("post_rst_in_ready", 256'(in_ready), 256'(1));
    end
    tick();

    // Single packet on port 2: visible two cycles after the handshake.
    p2 = mk(2, 32'h0000_1234);
    p2[0 +: 96] = {12{8'hA5}};
    in_packet = p2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("lat_not_yet", 256'(out_valid), 256'(0));
    tick();
    @(negedge clk);
    #1 chk("lat_valid", 256'(out_valid), 256'(1));
    chk("lat_channel", 256'(out_channel), 256'(2));
`ifndef DIRCC_LAMPORT_STAMP_EN
    chk("lat_packet", 256'(out_packet), 256'(p2));
`endif
    repeat (2) tick();

    // Fill channel 1 with out_ready low: first packet sits in the egress register.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_packet = mk(1 + 4 * i, $urandom);
      in_valid  = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    #1 chk("full_count1", 256'(chan_count[1*CNT_W +: CNT_W]), 256'(8));
    in_packet = mk(5, 32'd7);
    #1 chk("full_ready_p1", 256'(in_ready), 256'(0));
    in_packet = mk(0, 32'd7);
    #1 chk("full_ready_p0", 256'(in_ready), 256'(1));
    in_packet = mk(1, 32'd7);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("overflow_count1", 256'(chan_count[1*CNT_W +: CNT_W]), 256'(8));
    chk("overflow_count0", 256'(chan_count[0 +: CNT_W]), 256'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_valid || any_queued()); k++) tick();
    #1 chk("fill_drained", 256'(out_valid), 256'(0));

    // Round-robin order over channels 0, 1, 3.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_packet = mk(ports[i], $urandom);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("rr_valid", 256'(out_valid), 256'(1));
      chk("rr_channel", 256'(out_channel), 256'(order[i]));
      tick();
    end
    @(negedge clk);
    #1 chk("rr_empty", 256'(out_valid), 256'(0));
    tick();

    // Random traffic with random backpressure, 1000 accepted packets.
    base = m_pushed;
    cyc  = 0;
    while ((m_pushed - base) < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_packet = mk(int'($urandom_range(0, 255)), $urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
      cyc++;
    end
    chk("rand_pushed_1000", 256'((m_pushed - base) >= 1000), 256'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (exp_valid || any_queued()); k++) tick();
    chk("rand_drain_valid", 256'(out_valid), 256'(0));
    chk("rand_no_loss", 256'(m_delivered), 256'(m_pushed));

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_packet = mk(i, $urandom);
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_chan_count", 256'(chan_count), 256'(0));
    chk("midrst_in_ready", 256'(in_ready), 256'(0));
    repeat (2) tick();
    #1 reset_n = 1'b1;
    tick();

`ifdef DIRCC_LAMPORT_STAMP_EN
    // Lamport: hold a stamped packet in the register, then merge a larger timestamp.
    out_ready = 1'b0;
    in_packet = mk(0, 32'd3);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #1 chk("lam_setup_5", 256'(lamport_now), 256'(5));
    in_packet = mk(1, 32'd20);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("lam_ingress_21", 256'(lamport_now), 256'(21));
    out_ready = 1'b1;
    tick();
    #1 chk("lam_egress_ch", 256'(out_channel), 256'(1));
    chk("lam_egress_field", 256'(out_packet[LAM_LSB +: 32]), 256'(22));
    chk("lam_now_22", 256'(lamport_now), 256'(22));
    repeat (3) tick();
`endif

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
